data_mem_pipe: RTL and testbench

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/data_mem_pipe_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 53 +++++
 rtl/data_mem_pipe.sv | 159 +++++++++++++++
 tb/tb_data_mem_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pipe_pkg.sv
// Shared definitions for the pipelined data memory: access sizes, FSM
// state encoding and the byte-lane mask helper.
package data_mem_pipe_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte lanes touched by an access of the given size at the given offset,
  // for words of up to eight lanes; narrower words use the low bits.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SIZE_BYTE: base = 8'h01;
      SIZE_HALF: base = 8'h03;
      SIZE_WORD: base = 8'h0F;
      default:   base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: positions store data and its byte mask at
// the lane offset, and extracts/extends load data back down to bit 0.
module mem_lane_align
  import data_mem_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]                      size_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset_i,
  input  logic                            signed_i,
  input  logic [DATA_WIDTH-1:0]           store_data_i,
  input  logic [DATA_WIDTH-1:0]           load_word_i,
  output logic [DATA_WIDTH-1:0]           store_data_o,
  output logic [DATA_WIDTH/8-1:0]         byte_mask_o,
  output logic [DATA_WIDTH-1:0]           load_data_o
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shifted_s;
  logic [IDX_W-1:0]      msb_idx_s;
  logic                  fill_s;

  assign store_data_o = store_data_i << {offset_i, 3'b000};
  assign byte_mask_o  = LANES'(lane_mask(size_i, 3'(offset_i)));
  assign shifted_s    = load_word_i >> {offset_i, 3'b000};

  // Most significant bit of the loaded field; a full-width access keeps every bit.
  always_comb begin
    msb_idx_s = IDX_W'(DATA_WIDTH - 1);
    case (size_i)
      SIZE_BYTE: msb_idx_s = IDX_W'(6'd7);
      SIZE_HALF: msb_idx_s = IDX_W'(6'd15);
      SIZE_WORD: msb_idx_s = IDX_W'(6'd31);
      default:   msb_idx_s = IDX_W'(DATA_WIDTH - 1);
    endcase
  end

  // Keep the field bits and fill everything above with the sign or zero.
  always_comb begin
    load_data_o = '0;
    fill_s      = signed_i & shifted_s[msb_idx_s];
    for (int b = 0; b < DATA_WIDTH; b++) begin
      if (b <= int'(msb_idx_s)) begin
        load_data_o[b] = shifted_s[b];
      end else begin
        load_data_o[b] = fill_s;
      end
    end
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Single-outstanding data memory with byte/half/word/dword access,
// configurable response latency and a valid/ready response handshake.
module data_mem_pipe
  import data_mem_pipe_pkg::*;
#(
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       MEM_DEPTH     = 262144,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = ADDRESS_WIDTH'(32'h8002_0000),
  parameter int                       READ_LATENCY  = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [DATA_WIDTH-1:0]    req_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     resp_error
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int CNT_W     = 3;

  logic [DATA_WIDTH-1:0]    mem_q [MEM_DEPTH];

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     resp_valid_q;
  logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;
  logic                     resp_error_q, resp_error_d;

  logic [ADDRESS_WIDTH-1:0] diff_s, index_s;
  logic [IDX_W-1:0]         mem_idx_s;
  logic [2:0]               align_mask_s;
  logic                     range_err_s, align_err_s, size_err_s, err_s;
  logic                     accept_s;
  logic [DATA_WIDTH-1:0]    rd_word_s, wdata_s, load_data_s;
  logic [LANES-1:0]         wmask_s;

  // Address decode: offset from the base wraps, so low addresses land out of range.
  assign diff_s      = req_address - BASE_ADDRESS;
  assign index_s     = diff_s >> LANE_BITS;
  assign mem_idx_s   = index_s[IDX_W-1:0];
  assign range_err_s = (index_s >= ADDRESS_WIDTH'(MEM_DEPTH));
  assign align_err_s = |(req_address[2:0] & align_mask_s);
  assign size_err_s  = (req_size == SIZE_DWORD) && (DATA_WIDTH != 64);
  assign err_s       = range_err_s | align_err_s | size_err_s;
  assign accept_s    = req_valid && (state_q == ST_IDLE);
  assign rd_word_s   = mem_q[mem_idx_s];

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_error = resp_error_q;

  // Address bits that must be zero for a naturally aligned access.
  always_comb begin
    align_mask_s = 3'b111;
    case (req_size)
      SIZE_BYTE: align_mask_s = 3'b000;
      SIZE_HALF: align_mask_s = 3'b001;
      SIZE_WORD: align_mask_s = 3'b011;
      default:   align_mask_s = 3'b111;
    endcase
  end

  mem_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .size_i      (req_size),
    .offset_i    (req_address[LANE_BITS-1:0]),
    .signed_i    (req_signed),
    .store_data_i(req_data),
    .load_word_i (rd_word_s),
    .store_data_o(wdata_s),
    .byte_mask_o (wmask_s),
    .load_data_o (load_data_s)
  );

  // Byte-lane store at the accept edge; the array is never cleared by reset.
  always_ff @(posedge clock) begin
    if (accept_s && req_write && !err_s) begin
      for (int l = 0; l < LANES; l++) begin
        if (wmask_s[l]) begin
          mem_q[mem_idx_s][l*8 +: 8] <= wdata_s[l*8 +: 8];
        end
      end
    end
  end

  // Next state, latency countdown and response capture at accept.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          resp_data_d  = (req_write || err_s) ? '0 : load_data_s;
          resp_error_d = err_s;
          if (READ_LATENCY > 1) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(READ_LATENCY - 1);
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = ST_RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and registered response outputs; reset drops any pending response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= (state_d == ST_RESP);
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Scoreboard bench for data_mem_pipe: three configurations (32-bit latency 1,
// 32-bit latency 3, 64-bit latency 4) share one request bus; a monitor pops
// expected responses on every response handshake.
module tb_data_mem_pipe;

  typedef struct {
    logic [63:0] data;
    logic        err;
    string       name;
  } exp_t;

  logic        clock, reset_n;
  logic        req_valid, req_write, req_signed, resp_ready;
  logic [31:0] req_address;
  logic [1:0]  req_size;
  logic [63:0] req_data;
  int          sel;

  logic        a_rdy, a_vld, a_err, b_rdy, b_vld, b_err, c_rdy, c_vld, c_err;
  logic [31:0] a_data, b_data;
  logic [63:0] c_data;
  logic        cur_ready, cur_valid, cur_err;
  logic [63:0] cur_data;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          waits;

  data_mem_pipe #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .READ_LATENCY(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid && (sel == 0)), .req_ready(a_rdy),
    .req_write(req_write), .req_address(req_address), .req_size(req_size), .req_signed(req_signed),
    .req_data(req_data[31:0]), .resp_valid(a_vld), .resp_ready(resp_ready), .resp_data(a_data),
    .resp_error(a_err));

  data_mem_pipe #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .READ_LATENCY(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid && (sel == 1)), .req_ready(b_rdy),
    .req_write(req_write), .req_address(req_address), .req_size(req_size), .req_signed(req_signed),
    .req_data(req_data[31:0]), .resp_valid(b_vld), .resp_ready(resp_ready), .resp_data(b_data),
    .resp_error(b_err));

  data_mem_pipe #(.DATA_WIDTH(64), .MEM_DEPTH(1024), .READ_LATENCY(4)) dut_c (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid && (sel == 2)), .req_ready(c_rdy),
    .req_write(req_write), .req_address(req_address), .req_size(req_size), .req_signed(req_signed),
    .req_data(req_data), .resp_valid(c_vld), .resp_ready(resp_ready), .resp_data(c_data),
    .resp_error(c_err));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always_comb begin
    case (sel)
      0:       begin cur_ready = a_rdy; cur_valid = a_vld; cur_data = {32'h0, a_data}; cur_err = a_err; end
      1:       begin cur_ready = b_rdy; cur_valid = b_vld; cur_data = {32'h0, b_data}; cur_err = b_err; end
      default: begin cur_ready = c_rdy; cur_valid = c_vld; cur_data = c_data;          cur_err = c_err; end
    endcase
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every response handshake consumes the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && cur_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got data %0h err %0b, expected no response", cur_data, cur_err);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_data"}, cur_data, mon_e.data);
        check({mon_e.name, "_err"}, {63'h0, cur_err}, {63'h0, mon_e.err});
      end
    end
  end

  task automatic send(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [63:0] data, input logic [63:0] exp_d,
                      input logic exp_e, input string nm, input int lat, input logic push,
                      output int nwait);
    exp_t e;
    bit   acc;
    int   got;
    req_write = wr; req_address = addr; req_size = size; req_signed = sgn; req_data = data;
    req_valid = 1'b1;
    if (push) begin
      e.data = exp_d; e.err = exp_e; e.name = nm;
      sb_q.push_back(e);
    end
    nwait = 0;
    acc   = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      if (cur_ready) acc = 1'b1;
      else nwait++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept: got no accept in 50 cycles, expected accept", nm);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = ~wr; req_address = ~addr; req_size = ~size; req_signed = ~sgn; req_data = ~data;
    if (lat > 0) begin
      got = 0;
      for (int k = 1; k <= 20 && got == 0; k++) begin
        @(negedge clock);
        if (cur_valid) got = k;
      end
      check({nm, "_lat"}, 64'(got), 64'(lat));
    end
  endtask

  task automatic reset_pulse(input string nm);
    #2 reset_n = 1'b0;
    #1;
    check({nm, "_rst_valid"}, {63'h0, cur_valid}, 64'h0);
    check({nm, "_rst_data"}, cur_data, 64'h0);
    check({nm, "_rst_err"}, {63'h0, cur_err}, 64'h0);
    #3 reset_n = 1'b1;
    check({nm, "_rst_ready"}, {63'h0, cur_ready}, 64'h1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check({nm, "_no_resp"}, {63'h0, cur_valid}, 64'h0);
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1; sel = 0;
    req_write = 1'b0; req_address = 32'h0; req_size = 2'd0; req_signed = 1'b0; req_data = 64'h0;
    #3;
    check("reset_valid", {63'h0, cur_valid}, 64'h0);
    check("reset_data", cur_data, 64'h0);
    check("reset_err", {63'h0, cur_err}, 64'h0);
    #10 reset_n = 1'b1;
    #1 check("reset_ready", {63'h0, cur_ready}, 64'h1);
    @(posedge clock); #1;

    // 32-bit, latency 1
    send(1'b1, 32'h8002_0000, 2'd2, 1'b0, 64'hDEADBEEF, 64'h0,         1'b0, "a_st_word",  1, 1'b1, waits);
    send(1'b0, 32'h8002_0000, 2'd2, 1'b0, 64'h0,        64'hDEADBEEF,  1'b0, "a_ld_word",  1, 1'b1, waits);
    send(1'b1, 32'h8002_0001, 2'd0, 1'b0, 64'h80,       64'h0,         1'b0, "a_st_byte",  1, 1'b1, waits);
    send(1'b0, 32'h8002_0001, 2'd0, 1'b1, 64'h0,        64'hFFFFFF80,  1'b0, "a_ld_sbyte", 1, 1'b1, waits);
    send(1'b0, 32'h8002_0001, 2'd0, 1'b0, 64'h0,        64'h00000080,  1'b0, "a_ld_ubyte", 1, 1'b1, waits);
    send(1'b0, 32'h8002_0000, 2'd2, 1'b0, 64'h0,        64'hDEAD80EF,  1'b0, "a_ld_merge", 1, 1'b1, waits);
    send(1'b0, 32'h8002_0002, 2'd1, 1'b1, 64'h0,        64'hFFFFDEAD,  1'b0, "a_ld_shalf", 1, 1'b1, waits);
    send(1'b1, 32'h8002_0003, 2'd1, 1'b0, 64'h1234,     64'h0,         1'b1, "a_st_misal", 1, 1'b1, waits);
    send(1'b0, 32'h8002_0000, 2'd2, 1'b0, 64'h0,        64'hDEAD80EF,  1'b0, "a_ld_unchg", 1, 1'b1, waits);
    send(1'b0, 32'h8001_FFFC, 2'd2, 1'b0, 64'h0,        64'h0,         1'b1, "a_ld_below", 1, 1'b1, waits);
    send(1'b0, 32'h8002_0000, 2'd3, 1'b0, 64'h0,        64'h0,         1'b1, "a_ld_dword", 1, 1'b1, waits);
    send(1'b1, 32'h8002_0FFC, 2'd2, 1'b0, 64'hA5A55A5A, 64'h0,         1'b0, "a_st_last",  1, 1'b1, waits);
    send(1'b0, 32'h8002_0FFC, 2'd2, 1'b0, 64'h0,        64'hA5A55A5A,  1'b0, "a_ld_last",  1, 1'b1, waits);
    send(1'b0, 32'h8002_1000, 2'd2, 1'b0, 64'h0,        64'h0,         1'b1, "a_ld_over",  1, 1'b1, waits);
    @(posedge clock); #1;

    // 32-bit, latency 3, with a stalled consumer
    sel = 1;
    send(1'b1, 32'h8002_0004, 2'd2, 1'b0, 64'h11223344, 64'h0, 1'b0, "b_st_word", 3, 1'b1, waits);
    @(posedge clock); #1;
    resp_ready = 1'b0;
    send(1'b0, 32'h8002_0004, 2'd2, 1'b0, 64'h0, 64'h11223344, 1'b0, "b_ld_stall", 3, 1'b1, waits);
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h8002_0006; req_size = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("b_stall_valid", {63'h0, cur_valid}, 64'h1);
      check("b_stall_data", cur_data, 64'h11223344);
      check("b_stall_ready", {63'h0, cur_ready}, 64'h0);
    end
    @(posedge clock); #1;
    resp_ready = 1'b1;
    send(1'b0, 32'h8002_0006, 2'd1, 1'b0, 64'h0, 64'h00001122, 1'b0, "b_ld_uhalf", 3, 1'b1, waits);
    check("b_accept_after_hs", 64'(waits), 64'd1);
    @(posedge clock); #1;

    // 64-bit, latency 4, including reset during WAIT
    sel = 2;
    send(1'b1, 32'h8002_0000, 2'd3, 1'b0, 64'h0123456789ABCDEF, 64'h0, 1'b0, "c_st_dword", 4, 1'b1, waits);
    send(1'b0, 32'h8002_0006, 2'd1, 1'b1, 64'h0, 64'h0000000000000123, 1'b0, "c_ld_shalf", 4, 1'b1, waits);
    send(1'b0, 32'h8002_0000, 2'd0, 1'b1, 64'h0, 64'hFFFFFFFFFFFFFFEF, 1'b0, "c_ld_sbyte", 4, 1'b1, waits);
    send(1'b0, 32'h8002_0004, 2'd2, 1'b0, 64'h0, 64'h0000000001234567, 1'b0, "c_ld_uword", 4, 1'b1, waits);
    send(1'b0, 32'h8002_0002, 2'd2, 1'b0, 64'h0, 64'h0, 1'b1, "c_ld_misal", 4, 1'b1, waits);
    @(posedge clock); #1;
    send(1'b1, 32'h8002_0010, 2'd3, 1'b0, 64'hCAFEF00D12345678, 64'h0, 1'b0, "c_st_rst", 0, 1'b0, waits);
    reset_pulse("c_st_rst");
    @(posedge clock); #1;
    send(1'b0, 32'h8002_0000, 2'd3, 1'b0, 64'h0, 64'h0, 1'b0, "c_ld_rst", 0, 1'b0, waits);
    reset_pulse("c_ld_rst");
    @(posedge clock); #1;
    send(1'b0, 32'h8002_0010, 2'd3, 1'b0, 64'h0, 64'hCAFEF00D12345678, 1'b0, "c_ld_kept", 4, 1'b1, waits);
    send(1'b0, 32'h8002_0000, 2'd3, 1'b0, 64'h0, 64'h0123456789ABCDEF, 1'b0, "c_ld_noclr", 4, 1'b1, waits);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
